regfile_bist: RTL and testbench
===============================

REGFILE_BIST -- requirements
Module: regfile_bist

Interface
REQ-001 Parameters: none; register file fixed at 32 x 32-bit, 5-bit addresses.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  single-cycle request to begin a test run; sampled only in IDLE.
REQ-005 FirstReg  input  5  first register of test range; sampled on accepted Start.
REQ-006 LastReg  input  5  last register of test range, inclusive; sampled on accepted Start.
REQ-007 Mult  input  8  pattern multiplier; sampled on accepted Start.
REQ-008 WriteRegister  output  5  write address to register file.
REQ-009 WriteData  output  32  write data to register file.
REQ-010 RegWrite  output  1  write enable to register file.
REQ-011 ReadRegister1  output  5  read address, port 1.
REQ-012 ReadRegister2  output  5  read address, port 2.
REQ-013 ReadData1  input  32  read data, port 1, combinational from ReadRegister1.
REQ-014 ReadData2  input  32  read data, port 2, combinational from ReadRegister2.
REQ-015 Busy  output  1  high from the cycle after accepted Start until DONE.
REQ-016 Done  output  1  one-cycle pulse at end of run.
REQ-017 Pass  output  1  high when last completed run had zero mismatches; held until next accepted Start.
REQ-018 ErrorCount  output  6  mismatch count of current/last run, saturating at 63.
REQ-019 FailReg  output  5  register of first mismatch in last run; 0 if none.

Function
REQ-020 FSM states IDLE, WRITE, RD_ADDR, RD_CHECK, DONE; all outputs registered.
REQ-021 IDLE -> WRITE on Start=1 when FirstReg<=LastReg; latch range and Mult, clear ErrorCount, FailReg, Pass.
REQ-022 Start with FirstReg>LastReg -> DONE directly; no register-file access; Pass=1, ErrorCount=0.
REQ-023 Start while Busy is ignored.
REQ-024 Expected pattern for register r: r * Mult, zero-extended to 32 bits; for r=0 expected value is 0.
REQ-025 WRITE: one write per cycle, r = FirstReg..LastReg ascending; RegWrite=1, WriteRegister=r, WriteData=pattern(r); first write cycle is the cycle after Start acceptance.
REQ-026 Write index held in 6 bits so LastReg=31 terminates without wrap to 0.
REQ-027 WRITE -> RD_ADDR after write to LastReg; RegWrite=0 from that transition on.
REQ-028 RD_ADDR: ReadRegister1=r, ReadRegister2=r+1 (mod 32), r starting at FirstReg, stepping by 2.
REQ-029 RD_CHECK: compare ReadData1 vs pattern(r); compare ReadData2 vs pattern(r+1) only when r+1<=LastReg (odd-size range, no compare of port 2 on last pair).
REQ-030 Each mismatch increments ErrorCount (saturate 63); port-1 and port-2 mismatches in the same cycle count 2; FailReg records the lowest-numbered mismatching register of the first failing pair, port 1 having priority.
REQ-031 RD_CHECK -> RD_ADDR with r+=2 while r+2<=LastReg; otherwise -> DONE.
REQ-032 DONE: Done=1 for one cycle, Busy=0, Pass=(ErrorCount==0); next state IDLE.
REQ-033 Run length for N=LastReg-FirstReg+1 registers: N write cycles + 2*ceil(N/2) read cycles + 1 DONE cycle.
REQ-034 ReadRegister1/2 and WriteRegister/WriteData hold last values when not in use; RegWrite=0 outside WRITE.

Reset
REQ-035 Rst=1 forces IDLE immediately, independent of Clk, including mid-WRITE or mid-read.
REQ-036 Reset values: RegWrite=0, WriteRegister=0, WriteData=0, ReadRegister1=0, ReadRegister2=0, Busy=0, Done=0, Pass=0, ErrorCount=0, FailReg=0.
REQ-037 Reset during a run produces no Done pulse; a new Start is accepted on the first rising edge after Rst deasserts.

Verification
REQ-038 Start, FirstReg=8, LastReg=24, Mult=3, ideal register file -> 17 writes (reg8=24 ... reg24=72), 9 read pairs, Done after 17+18+1 cycles, Pass=1, ErrorCount=0.
REQ-039 Same run with register file forcing reg 13 to read 0 -> Pass=0, ErrorCount=1, FailReg=13.
REQ-040 FirstReg=30, LastReg=31, Mult=255 -> writes 7650, 7905; no write to reg 0; single pair read; Pass=1.
REQ-041 FirstReg=5, LastReg=5 -> one write, one pair read, port 2 unchecked even if corrupted, Pass=1; FirstReg=9, LastReg=8 -> Done one cycle after Start, RegWrite never high.
REQ-042 Assert Rst asynchronously mid-WRITE (between clock edges) -> RegWrite=0 and Busy=0 before next edge, no Done; Start after release completes a full passing run.

Source files
------------

// File: rtl/regfile_bist.sv
// Built-in self test for a 32 x 32-bit register file: writes r*Mult into a register range,
// reads it back two registers per cycle and reports mismatch count and first failing register.
module regfile_bist (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [4:0]  FirstReg,
  input  logic [4:0]  LastReg,
  input  logic [7:0]  Mult,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [5:0]  ErrorCount,
  output logic [4:0]  FailReg
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WRITE    = 3'd1;
  localparam logic [2:0] RD_ADDR  = 3'd2;
  localparam logic [2:0] RD_CHECK = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  function automatic logic [31:0] pattern(input logic [4:0] r, input logic [7:0] m);
    logic [12:0] p;
    p = {8'b0, r} * {5'b0, m};
    return {19'b0, p};
  endfunction

  logic [2:0]  stateQ, stateD;
  // Indices are 6 bits wide so a range ending at 31 terminates instead of wrapping to 0.
  logic [5:0]  firstQ, firstD, lastQ, lastD, idxQ, idxD;
  logic [7:0]  multQ, multD;
  logic [4:0]  writeRegQ, writeRegD, rdReg1Q, rdReg1D, rdReg2Q, rdReg2D, failRegQ, failRegD;
  logic [31:0] writeDataQ, writeDataD;
  logic        regWriteQ, regWriteD, busyQ, busyD, doneQ, doneD, passQ, passD;
  logic [5:0]  errQ, errD, errNext;
  logic [6:0]  errSum;
  logic [5:0]  nextIdx, idxStep, readIdx2;
  logic        mis1, mis2, check2;

  always_comb begin
    nextIdx  = idxQ + 6'd1;
    idxStep  = idxQ + 6'd2;
    readIdx2 = idxQ + 6'd1;
    check2   = (readIdx2 <= lastQ);
    mis1     = (ReadData1 != pattern(idxQ[4:0], multQ));
    mis2     = check2 && (ReadData2 != pattern(readIdx2[4:0], multQ));
    errSum   = {1'b0, errQ} + {6'b0, mis1} + {6'b0, mis2};
    errNext  = errSum[6] ? 6'd63 : errSum[5:0];
  end

  always_comb begin
    stateD     = stateQ;
    firstD     = firstQ;
    lastD      = lastQ;
    multD      = multQ;
    idxD       = idxQ;
    writeRegD  = writeRegQ;
    writeDataD = writeDataQ;
    rdReg1D    = rdReg1Q;
    rdReg2D    = rdReg2Q;
    failRegD   = failRegQ;
    errD       = errQ;
    busyD      = busyQ;
    passD      = passQ;
    regWriteD  = 1'b0;
    doneD      = 1'b0;
    case (stateQ)
      IDLE: begin
        if (Start) begin
          errD     = 6'd0;
          failRegD = 5'd0;
          if (FirstReg <= LastReg) begin
            stateD     = WRITE;
            firstD     = {1'b0, FirstReg};
            lastD      = {1'b0, LastReg};
            multD      = Mult;
            idxD       = {1'b0, FirstReg};
            regWriteD  = 1'b1;
            writeRegD  = FirstReg;
            writeDataD = pattern(FirstReg, Mult);
            busyD      = 1'b1;
            passD      = 1'b0;
          end else begin
            stateD = DONE;
            doneD  = 1'b1;
            busyD  = 1'b0;
            passD  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (idxQ == lastQ) begin
          stateD  = RD_ADDR;
          idxD    = firstQ;
          rdReg1D = firstQ[4:0];
          rdReg2D = firstQ[4:0] + 5'd1;
        end else begin
          idxD       = nextIdx;
          regWriteD  = 1'b1;
          writeRegD  = nextIdx[4:0];
          writeDataD = pattern(nextIdx[4:0], multQ);
        end
      end
      RD_ADDR: stateD = RD_CHECK;
      RD_CHECK: begin
        errD = errNext;
        // Only the first failing pair sets FailReg; port 1 wins within a pair.
        if (errQ == 6'd0 && (mis1 || mis2)) begin
          failRegD = mis1 ? idxQ[4:0] : readIdx2[4:0];
        end
        if (idxStep <= lastQ) begin
          stateD  = RD_ADDR;
          idxD    = idxStep;
          rdReg1D = idxStep[4:0];
          rdReg2D = idxStep[4:0] + 5'd1;
        end else begin
          stateD = DONE;
          doneD  = 1'b1;
          busyD  = 1'b0;
          passD  = (errNext == 6'd0);
        end
      end
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateQ     <= IDLE;
      firstQ     <= 6'd0;
      lastQ      <= 6'd0;
      multQ      <= 8'd0;
      idxQ       <= 6'd0;
      writeRegQ  <= 5'd0;
      writeDataQ <= 32'd0;
      rdReg1Q    <= 5'd0;
      rdReg2Q    <= 5'd0;
      failRegQ   <= 5'd0;
      errQ       <= 6'd0;
      busyQ      <= 1'b0;
      passQ      <= 1'b0;
      regWriteQ  <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      firstQ     <= firstD;
      lastQ      <= lastD;
      multQ      <= multD;
      idxQ       <= idxD;
      writeRegQ  <= writeRegD;
      writeDataQ <= writeDataD;
      rdReg1Q    <= rdReg1D;
      rdReg2Q    <= rdReg2D;
      failRegQ   <= failRegD;
      errQ       <= errD;
      busyQ      <= busyD;
      passQ      <= passD;
      regWriteQ  <= regWriteD;
      doneQ      <= doneD;
    end
  end

  assign WriteRegister = writeRegQ;
  assign WriteData     = writeDataQ;
  assign RegWrite      = regWriteQ;
  assign ReadRegister1 = rdReg1Q;
  assign ReadRegister2 = rdReg2Q;
  assign Busy          = busyQ;
  assign Done          = doneQ;
  assign Pass          = passQ;
  assign ErrorCount    = errQ;
  assign FailReg       = failRegQ;

endmodule

// File: tb/tb_regfile_bist.sv
// Scoreboard bench for regfile_bist: a behavioural register file with read-fault injection,
// expected writes and run results queued at Start, popped by a negedge monitor.
module tb_regfile_bist;

  logic        Clk = 1'b0;
  logic        Rst, Start;
  logic [4:0]  FirstReg, LastReg;
  logic [7:0]  Mult;
  logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2, FailReg;
  logic [31:0] WriteData, ReadData1, ReadData2;
  logic        RegWrite, Busy, Done, Pass;
  logic [5:0]  ErrorCount;

  regfile_bist dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .FirstReg(FirstReg), .LastReg(LastReg), .Mult(Mult),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Busy(Busy), .Done(Done), .Pass(Pass),
    .ErrorCount(ErrorCount), .FailReg(FailReg)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wrT;

  typedef struct {
    logic       pass;
    logic [5:0] err;
    logic [4:0] fail;
    int         cyc;
  } doneT;

  wrT   wrQ[$];
  doneT doneQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycleCnt = 0;
  int   badA = -1;
  int   badB = -1;
  logic [31:0] mem [32];

  // Register file model; reads of badA/badB come back inverted.
  always @(posedge Clk) if (RegWrite) mem[WriteRegister] <= WriteData;
  assign ReadData1 = mem[ReadRegister1] ^
      ((int'(ReadRegister1) == badA || int'(ReadRegister1) == badB) ? 32'hFFFF_FFFF : 32'h0);
  assign ReadData2 = mem[ReadRegister2] ^
      ((int'(ReadRegister2) == badA || int'(ReadRegister2) == badB) ? 32'hFFFF_FFFF : 32'h0);

  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  wrT   wrE;
  doneT doneE;
  always @(negedge Clk) begin
    if (!Rst) begin
      if (RegWrite) begin
        if (wrQ.size() == 0) flag("unexpected write");
        else begin
          wrE = wrQ.pop_front();
          check("write addr", 32'(WriteRegister), 32'(wrE.addr));
          check("write data", WriteData, wrE.data);
        end
      end
      if (Done) begin
        if (doneQ.size() == 0) flag("unexpected Done");
        else begin
          doneE = doneQ.pop_front();
          check("done cycle", cycleCnt, doneE.cyc);
          check("pass", 32'(Pass), 32'(doneE.pass));
          check("error count", 32'(ErrorCount), 32'(doneE.err));
          check("fail reg", 32'(FailReg), 32'(doneE.fail));
          check("busy in done", 32'(Busy), 32'd0);
        end
      end
    end
  end

  // Drive Start mid-cycle; queue the expected writes (if autoWr) and run result after acceptance.
  task automatic runStart(input int first, input int last, input int mult, input bit autoWr,
                          input bit expPass, input int expErr, input int expFail);
    int n;
    int c;
    Start = 1'b1;
    FirstReg = 5'(first);
    LastReg = 5'(last);
    Mult = 8'(mult);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    c = cycleCnt;
    n = (last >= first) ? last - first + 1 : 0;
    if (autoWr) for (int r = first; r <= last; r++) wrQ.push_back('{5'(r), 32'(r * mult)});
    doneQ.push_back('{expPass, 6'(expErr), 5'(expFail), c + n + 2 * ((n + 1) / 2)});
    check("busy after start", 32'(Busy), 32'(n > 0));
  endtask

  task automatic waitDone();
    for (int i = 0; i < 200 && doneQ.size() != 0; i++) @(posedge Clk);
    if (doneQ.size() != 0) begin
      flag("done timeout");
      doneQ.delete();
    end
    if (wrQ.size() != 0) begin
      flag("missing writes");
      wrQ.delete();
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    Rst = 1'b1;
    Start = 1'b0;
    FirstReg = 5'd0;
    LastReg = 5'd0;
    Mult = 8'd0;
    #12;
    check("rst RegWrite", 32'(RegWrite), 32'd0);
    check("rst WriteRegister", 32'(WriteRegister), 32'd0);
    check("rst WriteData", WriteData, 32'd0);
    check("rst ReadRegister1", 32'(ReadRegister1), 32'd0);
    check("rst ReadRegister2", 32'(ReadRegister2), 32'd0);
    check("rst Busy", 32'(Busy), 32'd0);
    check("rst Done", 32'(Done), 32'd0);
    check("rst Pass", 32'(Pass), 32'd0);
    check("rst ErrorCount", 32'(ErrorCount), 32'd0);
    check("rst FailReg", 32'(FailReg), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // 8..24 x3, with a stray Start (empty range) while busy that must be ignored.
    runStart(8, 24, 3, 1'b1, 1'b1, 0, 0);
    repeat (3) @(posedge Clk);
    #1;
    Start = 1'b1;
    FirstReg = 5'd9;
    LastReg = 5'd8;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    waitDone();

    // Same run with register 13 reading back wrong (seen on port 2 of pair 12/13).
    badA = 13;
    runStart(8, 24, 3, 1'b1, 1'b0, 1, 13);
    waitDone();
    badA = -1;

    // Top of the file: 30*255 and 31*255, no wrap to register 0.
    wrQ.push_back('{5'd30, 32'd7650});
    wrQ.push_back('{5'd31, 32'd7905});
    runStart(30, 31, 255, 1'b0, 1'b1, 0, 0);
    waitDone();

    // Single register: port 2 (register 6) corrupted but never checked.
    badA = 6;
    runStart(5, 5, 7, 1'b1, 1'b1, 0, 0);
    waitDone();
    badA = -1;

    // Empty range: Done in the cycle after Start, no writes.
    runStart(9, 8, 4, 1'b1, 1'b1, 0, 0);
    waitDone();

    // Both ports of pair 4/5 fail: count 2, port 1 register reported.
    badA = 4;
    badB = 5;
    runStart(2, 5, 1, 1'b1, 1'b0, 2, 4);
    waitDone();
    badA = -1;
    badB = -1;
    repeat (3) @(posedge Clk);
    #1;
    check("pass held low", 32'(Pass), 32'd0);
    check("errcount held", 32'(ErrorCount), 32'd2);

    // Full file including register 0.
    runStart(0, 31, 200, 1'b1, 1'b1, 0, 0);
    waitDone();
    repeat (2) @(posedge Clk);
    #1;
    check("pass held high", 32'(Pass), 32'd1);

    // Asynchronous reset in the middle of the write phase.
    runStart(8, 24, 3, 1'b1, 1'b1, 0, 0);
    repeat (4) @(posedge Clk);
    #2;
    check("writing before reset", 32'(RegWrite), 32'd1);
    Rst = 1'b1;
    #1;
    check("async RegWrite", 32'(RegWrite), 32'd0);
    check("async Busy", 32'(Busy), 32'd0);
    check("async Done", 32'(Done), 32'd0);
    wrQ.delete();
    doneQ.delete();
    repeat (2) @(posedge Clk);
    #3;
    Rst = 1'b0;
    runStart(8, 24, 3, 1'b1, 1'b1, 0, 0);
    waitDone();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
